// File: rtl/register_bank.sv
// Multi-register storage: one write port (load/inc/dec/clr), two combinational read ports and a
// registered wrap flag. Define WRITE_BYPASS_EN to forward the pending write value onto read ports.
module register_bank #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned    SW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             we,
    input  logic [SW-1:0]    wsel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [SW-1:0]    rsel_a,
    input  logic [SW-1:0]    rsel_b,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic             carry
);

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpInc  = 2'b01,
        OpDec  = 2'b10,
        OpClr  = 2'b11
    } op_e;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_carry;

    logic             w_hit;
    logic             w_wr_valid;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_next;
    logic             w_carry_next;

    // Index decode by loop so out-of-range selects simply match nothing.
    always_comb begin
        w_hit = 1'b0;
        w_cur = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wsel == SW'(i)) begin
                w_hit = 1'b1;
                w_cur = r_regs[i];
            end
        end
    end

    assign w_wr_valid = we & w_hit;

    always_comb begin
        w_next       = '0;
        w_carry_next = 1'b0;
        unique case (op_e'(op))
            OpLoad: w_next = d;
            OpInc: begin
                w_next       = w_cur + WIDTH'(1);
                w_carry_next = &w_cur;
            end
            OpDec: begin
                w_next       = w_cur - WIDTH'(1);
                w_carry_next = ~|w_cur;
            end
            OpClr: w_next = '0;
            default: w_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_carry <= 1'b0;
        end else if (w_wr_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wsel == SW'(i)) begin
                    r_regs[i] <= w_next;
                end
            end
            r_carry <= w_carry_next;
        end
    end

    always_comb begin
        q_a = '0;
        q_b = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rsel_a == SW'(i)) q_a = r_regs[i];
            if (rsel_b == SW'(i)) q_b = r_regs[i];
        end
`ifdef WRITE_BYPASS_EN
        if (w_wr_valid && (rsel_a == wsel)) q_a = w_next;
        if (w_wr_valid && (rsel_b == wsel)) q_b = w_next;
`else
`endif
    end

    assign carry = r_carry;

endmodule
